// File: rtl/dsp_slice_pkg.sv
// Shared constants and types for the DSP MAC slice: OPMODE field positions,
// X/Z multiplexer encodings and the product-width helper.
package dsp_slice_pkg;

  localparam int OP_X_LSB    = 0;
  localparam int OP_Z_LSB    = 2;
  localparam int OP_PRE_EN   = 4;
  localparam int OP_PRE_SUB  = 5;
  localparam int OP_POST_SUB = 6;
  localparam int OP_CIN_EN   = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

  // A times a (B_W+1)-bit pre-adder result needs one extra bit over A_W+B_W.
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

endpackage

// File: rtl/dsp_mac_slice_if.sv
// Operand/result bundle of the DSP MAC slice; the master drives operands and
// the slice (slave) returns the result, cascade and status outputs.
interface dsp_mac_slice_if
#(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int C_W = 48,
  parameter int P_W = 48
);
  import dsp_slice_pkg::*;

  logic                                 CE;
  logic                                 in_valid;
  logic signed [A_W-1:0]                A;
  logic signed [B_W-1:0]                B;
  logic signed [B_W-1:0]                D;
  logic signed [C_W-1:0]                C;
  logic signed [P_W-1:0]                PCIN;
  logic                                 CARRYIN;
  logic        [7:0]                    OPMODE;
  logic signed [P_W-1:0]                P;
  logic signed [P_W-1:0]                PCOUT;
  logic signed [prod_w(A_W, B_W)-1:0]   M;
  logic signed [B_W-1:0]                BCOUT;
  logic                                 CARRYOUT;
  logic                                 out_valid;
  logic                                 OVF;

  modport master (
    output CE, in_valid, A, B, D, C, PCIN, CARRYIN, OPMODE,
    input  P, PCOUT, M, BCOUT, CARRYOUT, out_valid, OVF
  );

  modport slave (
    input  CE, in_valid, A, B, D, C, PCIN, CARRYIN, OPMODE,
    output P, PCOUT, M, BCOUT, CARRYOUT, out_valid, OVF
  );

endinterface

// File: rtl/dsp_preadd_mult.sv
// Pre-adder and signed multiplier stage of the MAC slice, with optional product
// register (MREG) and the registered pre-adder output driven onto BCOUT.
module dsp_preadd_mult
  import dsp_slice_pkg::*;
#(
  parameter int A_W  = 18,
  parameter int B_W  = 18,
  parameter int MREG = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ce,
  input  logic                               ld,
  input  logic signed [A_W-1:0]              a,
  input  logic signed [B_W-1:0]              b,
  input  logic signed [B_W-1:0]              d,
  input  logic                               pre_en,
  input  logic                               pre_sub,
  output logic signed [prod_w(A_W, B_W)-1:0] m,
  output logic signed [B_W-1:0]              bcout
);
  localparam int M_W = prod_w(A_W, B_W);

  logic signed [B_W:0]   b_x, d_x, bp;
  logic signed [M_W-1:0] a_m, bp_m, prod;
  logic signed [B_W-1:0] bcout_p2_q, bcout_p2_d;

  always_comb begin
    b_x  = (B_W+1)'(b);
    d_x  = (B_W+1)'(d);
    bp   = b_x;
    if (pre_en) bp = pre_sub ? (d_x - b_x) : (d_x + b_x);
    a_m  = M_W'(a);
    bp_m = M_W'(bp);
    prod = a_m * bp_m;
    bcout_p2_d = bcout_p2_q;
    if (ce && ld) bcout_p2_d = bp[B_W-1:0];
  end

  // ---- S2 register boundary ----
  always_ff @(posedge clk) begin
    if (rst) bcout_p2_q <= '0;
    else     bcout_p2_q <= bcout_p2_d;
  end

  assign bcout = bcout_p2_q;

  generate
    if (MREG != 0) begin : g_mreg
      logic signed [M_W-1:0] m_p2_q, m_p2_d;

      always_comb begin
        m_p2_d = m_p2_q;
        if (ce && ld) m_p2_d = prod;
      end

      always_ff @(posedge clk) begin
        if (rst) m_p2_q <= '0;
        else     m_p2_q <= m_p2_d;
      end

      assign m = m_p2_q;
    end else begin : g_nomreg
      assign m = prod;
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_slice.sv
// DSP MAC slice top: input registers, pre-add/multiply, post-adder/accumulator
// with valid tracking and sticky overflow. Define DSP_SAT_EN for saturation.
module dsp_mac_slice
  import dsp_slice_pkg::*;
#(
  parameter int A_W  = 18,
  parameter int B_W  = 18,
  parameter int C_W  = 48,
  parameter int P_W  = 48,
  parameter int MREG = 1
) (
  input logic            clk,
  input logic            RST,
  dsp_mac_slice_if.slave bus
);
  localparam int M_W   = prod_w(A_W, B_W);
  localparam int DAB_W = 2*B_W + A_W;

  logic signed [A_W-1:0] a_p1_q, a_p1_d;
  logic signed [B_W-1:0] b_p1_q, b_p1_d, d_p1_q, d_p1_d;
  logic signed [C_W-1:0] c_p1_q, c_p1_d;
  logic signed [P_W-1:0] pcin_p1_q, pcin_p1_d;
  logic                  cin_p1_q, cin_p1_d;
  logic        [7:0]     op_p1_q, op_p1_d;
  logic                  vld_p1_q, vld_p1_d;

  // Data registers only load on a valid beat so M/BCOUT keep the last result.
  always_comb begin
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    d_p1_d    = d_p1_q;
    c_p1_d    = c_p1_q;
    pcin_p1_d = pcin_p1_q;
    cin_p1_d  = cin_p1_q;
    op_p1_d   = op_p1_q;
    vld_p1_d  = vld_p1_q;
    if (bus.CE) begin
      vld_p1_d = bus.in_valid;
      if (bus.in_valid) begin
        a_p1_d    = bus.A;
        b_p1_d    = bus.B;
        d_p1_d    = bus.D;
        c_p1_d    = bus.C;
        pcin_p1_d = bus.PCIN;
        cin_p1_d  = bus.CARRYIN;
        op_p1_d   = bus.OPMODE;
      end
    end
  end

  // ---- S1 register boundary ----
  always_ff @(posedge clk) begin
    if (RST) begin
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      d_p1_q    <= '0;
      c_p1_q    <= '0;
      pcin_p1_q <= '0;
      cin_p1_q  <= 1'b0;
      op_p1_q   <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      d_p1_q    <= d_p1_d;
      c_p1_q    <= c_p1_d;
      pcin_p1_q <= pcin_p1_d;
      cin_p1_q  <= cin_p1_d;
      op_p1_q   <= op_p1_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  logic signed [M_W-1:0] m_s3;
  logic signed [B_W-1:0] bcout;

  dsp_preadd_mult #(
    .A_W (A_W),
    .B_W (B_W),
    .MREG(MREG)
  ) u_preadd_mult (
    .clk    (clk),
    .rst    (RST),
    .ce     (bus.CE),
    .ld     (vld_p1_q),
    .a      (a_p1_q),
    .b      (b_p1_q),
    .d      (d_p1_q),
    .pre_en (op_p1_q[OP_PRE_EN]),
    .pre_sub(op_p1_q[OP_PRE_SUB]),
    .m      (m_s3),
    .bcout  (bcout)
  );

  x_sel_e             xsel_p1, xsel_s3;
  z_sel_e             zsel_p1, zsel_s3;
  logic               sub_p1, sub_s3, cine_p1, cin_s3, vld_s3;
  logic [DAB_W-1:0]   dab_p1, dab_s3;
  logic signed [C_W-1:0] c_s3;
  logic signed [P_W-1:0] pcin_s3;

  assign xsel_p1 = x_sel_e'(op_p1_q[OP_X_LSB +: 2]);
  assign zsel_p1 = z_sel_e'(op_p1_q[OP_Z_LSB +: 2]);
  assign sub_p1  = op_p1_q[OP_POST_SUB];
  assign cine_p1 = op_p1_q[OP_CIN_EN] & cin_p1_q;
  assign dab_p1  = {d_p1_q, a_p1_q, b_p1_q};

  // Post-adder controls follow the product so they stay aligned with M.
  generate
    if (MREG != 0) begin : g_ctl_p2
      x_sel_e                xsel_p2_q, xsel_p2_d;
      z_sel_e                zsel_p2_q, zsel_p2_d;
      logic                  sub_p2_q, sub_p2_d, cin_p2_q, cin_p2_d;
      logic                  vld_p2_q, vld_p2_d;
      logic [DAB_W-1:0]      dab_p2_q, dab_p2_d;
      logic signed [C_W-1:0] c_p2_q, c_p2_d;
      logic signed [P_W-1:0] pcin_p2_q, pcin_p2_d;

      always_comb begin
        xsel_p2_d = xsel_p2_q;
        zsel_p2_d = zsel_p2_q;
        sub_p2_d  = sub_p2_q;
        cin_p2_d  = cin_p2_q;
        dab_p2_d  = dab_p2_q;
        c_p2_d    = c_p2_q;
        pcin_p2_d = pcin_p2_q;
        vld_p2_d  = vld_p2_q;
        if (bus.CE) begin
          vld_p2_d = vld_p1_q;
          if (vld_p1_q) begin
            xsel_p2_d = xsel_p1;
            zsel_p2_d = zsel_p1;
            sub_p2_d  = sub_p1;
            cin_p2_d  = cine_p1;
            dab_p2_d  = dab_p1;
            c_p2_d    = c_p1_q;
            pcin_p2_d = pcin_p1_q;
          end
        end
      end

      // ---- S2 register boundary ----
      always_ff @(posedge clk) begin
        if (RST) begin
          xsel_p2_q <= X_ZERO;
          zsel_p2_q <= Z_ZERO;
          sub_p2_q  <= 1'b0;
          cin_p2_q  <= 1'b0;
          dab_p2_q  <= '0;
          c_p2_q    <= '0;
          pcin_p2_q <= '0;
          vld_p2_q  <= 1'b0;
        end else begin
          xsel_p2_q <= xsel_p2_d;
          zsel_p2_q <= zsel_p2_d;
          sub_p2_q  <= sub_p2_d;
          cin_p2_q  <= cin_p2_d;
          dab_p2_q  <= dab_p2_d;
          c_p2_q    <= c_p2_d;
          pcin_p2_q <= pcin_p2_d;
          vld_p2_q  <= vld_p2_d;
        end
      end

      assign xsel_s3 = xsel_p2_q;
      assign zsel_s3 = zsel_p2_q;
      assign sub_s3  = sub_p2_q;
      assign cin_s3  = cin_p2_q;
      assign dab_s3  = dab_p2_q;
      assign c_s3    = c_p2_q;
      assign pcin_s3 = pcin_p2_q;
      assign vld_s3  = vld_p2_q;
    end else begin : g_ctl_p1
      assign xsel_s3 = xsel_p1;
      assign zsel_s3 = zsel_p1;
      assign sub_s3  = sub_p1;
      assign cin_s3  = cine_p1;
      assign dab_s3  = dab_p1;
      assign c_s3    = c_p1_q;
      assign pcin_s3 = pcin_p1_q;
      assign vld_s3  = vld_p1_q;
    end
  endgenerate

  logic signed [P_W-1:0] p_p3_q, p_p3_d;
  logic                  co_p3_q, co_p3_d, ovf_q, ovf_d, vld_p3_q, vld_p3_d;
  logic signed [P_W-1:0] x_val, z_val, res;
  logic        [P_W:0]   raw;
  logic signed [P_W+1:0] ext_x, ext_z, ext_cin, ext;
  logic                  co_now, ovf_now;

  // raw gives the unsigned carry/borrow; ext is the exact signed result used
  // to detect overflow of the P_W-bit value.
  always_comb begin
    case (xsel_s3)
      X_M:     x_val = P_W'(m_s3);
      X_P:     x_val = p_p3_q;
      X_DAB:   x_val = P_W'(dab_s3);
      default: x_val = '0;
    endcase
    case (zsel_s3)
      Z_PCIN:  z_val = pcin_s3;
      Z_P:     z_val = p_p3_q;
      Z_C:     z_val = P_W'(c_s3);
      default: z_val = '0;
    endcase
    ext_x   = (P_W+2)'(x_val);
    ext_z   = (P_W+2)'(z_val);
    ext_cin = {{(P_W+1){1'b0}}, cin_s3};
    if (sub_s3) begin
      raw = {1'b0, z_val} - {1'b0, x_val} - {{P_W{1'b0}}, cin_s3};
      ext = ext_z - ext_x - ext_cin;
    end else begin
      raw = {1'b0, z_val} + {1'b0, x_val} + {{P_W{1'b0}}, cin_s3};
      ext = ext_z + ext_x + ext_cin;
    end
    res     = raw[P_W-1:0];
    co_now  = raw[P_W];
    ovf_now = (ext != (P_W+2)'(res));
`ifdef DSP_SAT_EN
    if (ovf_now) begin
      res    = ext[P_W+1] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
      co_now = 1'b0;
    end
`endif

    p_p3_d   = p_p3_q;
    co_p3_d  = co_p3_q;
    ovf_d    = ovf_q;
    vld_p3_d = bus.CE & vld_s3;
    if (bus.CE && vld_s3) begin
      p_p3_d  = res;
      co_p3_d = co_now;
      ovf_d   = ovf_q | ovf_now;
    end
  end

  // ---- S3 register boundary ----
  always_ff @(posedge clk) begin
    if (RST) begin
      p_p3_q   <= '0;
      co_p3_q  <= 1'b0;
      ovf_q    <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      p_p3_q   <= p_p3_d;
      co_p3_q  <= co_p3_d;
      ovf_q    <= ovf_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  assign bus.P         = p_p3_q;
  assign bus.PCOUT     = p_p3_q;
  assign bus.M         = m_s3;
  assign bus.BCOUT     = bcout;
  assign bus.CARRYOUT  = co_p3_q;
  assign bus.out_valid = vld_p3_q;
  assign bus.OVF       = ovf_q;

endmodule
